// File: rtl/backdoor_pkg.sv
// Shared types and constants for the backdoor host-to-memory bridge.
package backdoor_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LAST_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_RESP} state_t;
  typedef enum logic [1:0] {KIND_NONE, KIND_ROM, KIND_RAM, KIND_CTRL} kind_t;

  localparam logic [SEL_W-1:0] SEL_ROM_BASE = 4'h0;
  localparam logic [SEL_W-1:0] SEL_RAM_BASE = 4'h8;
  localparam logic [SEL_W-1:0] SEL_CTRL     = 4'hF;

  localparam int unsigned CTRL_HOLD_BIT = 0;
  localparam int unsigned CTRL_TO_BIT   = 1;
  localparam int unsigned CTRL_LAST_LSB = 4;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we;
  } dev_req_t;

  // Read image of the control register; unlisted bits read as zero.
  function automatic logic [DATA_W-1:0] ctrl_word(input logic hold, input logic to,
                                                  input logic [LAST_W-1:0] last);
    logic [DATA_W-1:0] w;
    w = '0;
    w[CTRL_HOLD_BIT] = hold;
    w[CTRL_TO_BIT] = to;
    w[CTRL_LAST_LSB +: LAST_W] = last;
    return w;
  endfunction

endpackage

// File: rtl/backdoor_decode.sv
// Target-select decode: 4-bit select into target kind, port index and one-hot strobes.
module backdoor_decode
  import backdoor_pkg::*;
#(
  parameter int unsigned NUM_ROM = 5,
  parameter int unsigned NUM_RAM = 2
) (
  input  logic [SEL_W-1:0]   sel,
  output kind_t              kind_c,
  output logic [SEL_W-1:0]   index_c,
  output logic [NUM_ROM-1:0] rom_hot_c,
  output logic [NUM_RAM-1:0] ram_hot_c
);

  always_comb begin
    kind_c    = KIND_NONE;
    index_c   = '0;
    rom_hot_c = '0;
    ram_hot_c = '0;
    for (int i = 0; i < int'(NUM_ROM); i++) begin
      if (sel == SEL_ROM_BASE + SEL_W'(i)) begin
        kind_c       = KIND_ROM;
        index_c      = SEL_W'(i);
        rom_hot_c[i] = 1'b1;
      end
    end
    for (int i = 0; i < int'(NUM_RAM); i++) begin
      if (sel == SEL_RAM_BASE + SEL_W'(i)) begin
        kind_c       = KIND_RAM;
        index_c      = SEL_W'(i);
        ram_hot_c[i] = 1'b1;
      end
    end
    if (sel == SEL_CTRL) kind_c = KIND_CTRL;
  end

endmodule

// File: rtl/backdoor_ctrl.sv
// Host slave that forwards backdoor accesses to one of several ROM/RAM ports,
// with a wait timeout and a small control register holding the CPU in reset.
module backdoor_ctrl
  import backdoor_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned NUM_ROM = 5,
  parameter int unsigned NUM_RAM = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       wb_data_i,
  input  logic [ADDR_W-1:0]       wb_addr_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_strobe_i,
  input  logic                    wb_we_i,
  output logic [DATA_W-1:0]       wb_data_o,
  output logic                    wb_ack_o,
  output logic [ADDR_W-1:0]       dev_addr_o,
  output logic [DATA_W-1:0]       dev_data_o,
  output logic                    dev_we_o,
  output logic [NUM_ROM-1:0]      rom_cyc_o,
  output logic [NUM_ROM-1:0]      rom_strobe_o,
  input  logic [32*NUM_ROM-1:0]   rom_data_i,
  input  logic [NUM_ROM-1:0]      rom_ack_i,
  output logic [NUM_RAM-1:0]      ram_cyc_o,
  output logic [NUM_RAM-1:0]      ram_strobe_o,
  input  logic [32*NUM_RAM-1:0]   ram_data_i,
  input  logic [NUM_RAM-1:0]      ram_ack_i,
  output logic                    cpu_hold_o
);

  state_t              state_q, state_d;
  kind_t               kind_q, kind_d, kind_c;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d, idx_q, idx_d, idx_c;
  logic [NUM_ROM-1:0]  rom_sel_q, rom_sel_d, rom_hot_c;
  logic [NUM_RAM-1:0]  ram_sel_q, ram_sel_d, ram_hot_c;
  dev_req_t            dev_q, dev_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, dev_rdata_c;
  logic                hold_q, hold_d, to_q, to_d;
  logic [LAST_W-1:0]   last_to_q, last_to_d;
  logic                dev_ack_c;
  logic                unused_addr_c;

  assign unused_addr_c = ^wb_addr_i[ADDR_W-1:24];

  backdoor_decode #(.NUM_ROM(NUM_ROM), .NUM_RAM(NUM_RAM)) u_decode (
    .sel       (wb_addr_i[23:20]),
    .kind_c    (kind_c),
    .index_c   (idx_c),
    .rom_hot_c (rom_hot_c),
    .ram_hot_c (ram_hot_c)
  );

  // Only the port currently strobed may complete the transfer.
  assign dev_ack_c = (|(rom_ack_i & rom_sel_q)) | (|(ram_ack_i & ram_sel_q));

  always_comb begin
    dev_rdata_c = '0;
    for (int i = 0; i < int'(NUM_ROM); i++)
      if (kind_q == KIND_ROM && idx_q == SEL_W'(i)) dev_rdata_c = rom_data_i[32*i +: 32];
    for (int i = 0; i < int'(NUM_RAM); i++)
      if (kind_q == KIND_RAM && idx_q == SEL_W'(i)) dev_rdata_c = ram_data_i[32*i +: 32];
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    rom_sel_d = rom_sel_q;
    ram_sel_d = ram_sel_q;
    dev_d     = dev_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    hold_d    = hold_q;
    to_d      = to_q;
    last_to_d = last_to_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_strobe_i) begin
          dev_d.addr = {12'h0, wb_addr_i[19:0]};
          dev_d.data = wb_data_i;
          dev_d.we   = wb_we_i;
          sel_d      = wb_addr_i[23:20];
          kind_d     = kind_c;
          idx_d      = idx_c;
          cnt_d      = '0;
          if (kind_c == KIND_ROM || kind_c == KIND_RAM) begin
            rom_sel_d = rom_hot_c;
            ram_sel_d = ram_hot_c;
            state_d   = ST_FWD;
          end else begin
            ack_d   = 1'b1;
            rdata_d = (kind_c == KIND_CTRL) ? ctrl_word(hold_q, to_q, last_to_q) : '0;
            state_d = ST_RESP;
          end
        end
      end
      ST_FWD: begin
        if (!wb_cyc_i) begin
          rom_sel_d = '0;
          ram_sel_d = '0;
          state_d   = ST_IDLE;
        end else if (dev_ack_c) begin
          rom_sel_d = '0;
          ram_sel_d = '0;
          ack_d     = 1'b1;
          rdata_d   = dev_rdata_c;
          state_d   = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rom_sel_d = '0;
          ram_sel_d = '0;
          ack_d     = 1'b1;
          rdata_d   = TIMEOUT_DATA;
          to_d      = 1'b1;
          last_to_d = sel_q;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        // Control writes land as the ack retires, so cpu_hold moves the cycle after.
        if (kind_q == KIND_CTRL && dev_q.we) begin
          hold_d = dev_q.data[CTRL_HOLD_BIT];
          if (dev_q.data[CTRL_TO_BIT]) to_d = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      kind_q    <= KIND_NONE;
      cnt_q     <= '0;
      sel_q     <= '0;
      idx_q     <= '0;
      rom_sel_q <= '0;
      ram_sel_q <= '0;
      dev_q     <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      hold_q    <= 1'b1;
      to_q      <= 1'b0;
      last_to_q <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      rom_sel_q <= rom_sel_d;
      ram_sel_q <= ram_sel_d;
      dev_q     <= dev_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      hold_q    <= hold_d;
      to_q      <= to_d;
      last_to_q <= last_to_d;
    end
  end

  assign wb_data_o    = rdata_q;
  assign wb_ack_o     = ack_q;
  assign dev_addr_o   = dev_q.addr;
  assign dev_data_o   = dev_q.data;
  assign dev_we_o     = dev_q.we;
  assign rom_cyc_o    = rom_sel_q;
  assign rom_strobe_o = rom_sel_q;
  assign ram_cyc_o    = ram_sel_q;
  assign ram_strobe_o = ram_sel_q;
  assign cpu_hold_o   = hold_q;

endmodule

// File: tb/tb_backdoor_ctrl.sv
// Directed bench for backdoor_ctrl: control register, ROM/RAM forwarding, timeout,
// unmapped targets, host abort and asynchronous reset.
module tb_backdoor_ctrl;

  localparam int unsigned NROM = 5;
  localparam int unsigned NRAM = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [31:0]       wb_data_i, wb_addr_i, wb_data_o;
  logic              wb_cyc_i, wb_strobe_i, wb_we_i, wb_ack_o;
  logic [31:0]       dev_addr_o, dev_data_o;
  logic              dev_we_o;
  logic [NROM-1:0]   rom_cyc_o, rom_strobe_o, rom_ack_i;
  logic [32*NROM-1:0] rom_data_i;
  logic [NRAM-1:0]   ram_cyc_o, ram_strobe_o, ram_ack_i;
  logic [32*NRAM-1:0] ram_data_i;
  logic              cpu_hold_o;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  backdoor_ctrl #(.TIMEOUT(15), .NUM_ROM(NROM), .NUM_RAM(NRAM)) dut (
    .clock(clock), .reset(reset),
    .wb_data_i(wb_data_i), .wb_addr_i(wb_addr_i), .wb_cyc_i(wb_cyc_i),
    .wb_strobe_i(wb_strobe_i), .wb_we_i(wb_we_i), .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o),
    .dev_addr_o(dev_addr_o), .dev_data_o(dev_data_o), .dev_we_o(dev_we_o),
    .rom_cyc_o(rom_cyc_o), .rom_strobe_o(rom_strobe_o), .rom_data_i(rom_data_i), .rom_ack_i(rom_ack_i),
    .ram_cyc_o(ram_cyc_o), .ram_strobe_o(ram_strobe_o), .ram_data_i(ram_data_i), .ram_ack_i(ram_ack_i),
    .cpu_hold_o(cpu_hold_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [31:0] addr, input logic [31:0] data, input logic we);
    wb_addr_i = addr;
    wb_data_i = data;
    wb_we_i = we;
    wb_cyc_i = 1'b1;
    wb_strobe_i = 1'b1;
  endtask

  // Edges until ack is seen, bounded; 64 means it never came.
  task automatic wait_ack(output int n);
    n = 64;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clock); #1;
      if (wb_ack_o) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic end_req();
    wb_cyc_i = 1'b0;
    wb_strobe_i = 1'b0;
    wb_we_i = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic ctrl_read(input string tag, input logic [31:0] exp);
    int n;
    start_req(32'h00F00000, 32'h0, 1'b0);
    wait_ack(n);
    chk({tag, "_lat"}, 32'(n), 32'd1);
    chk(tag, wb_data_o, exp);
    end_req();
  endtask

  task automatic ctrl_write(input logic [31:0] data);
    int n;
    start_req(32'h00F00000, data, 1'b1);
    wait_ack(n);
    end_req();
  endtask

  initial begin
    reset = 1'b0;
    wb_data_i = '0; wb_addr_i = '0; wb_cyc_i = 1'b0; wb_strobe_i = 1'b0; wb_we_i = 1'b0;
    rom_ack_i = '0;
    ram_ack_i = '0;
    rom_data_i = {32'h44444444, 32'h33333333, 32'h12345678, 32'h11111111, 32'h0BADF00D};
    ram_data_i = {32'hBBBBBBBB, 32'hAAAAAAAA};
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_data", wb_data_o, 32'h0);
    chk("rst_hold", 32'(cpu_hold_o), 32'd1);
    chk("rst_rom_cyc", 32'(rom_cyc_o), 32'h0);
    chk("rst_ram_cyc", 32'(ram_cyc_o), 32'h0);
    chk("rst_dev_addr", dev_addr_o, 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rel_hold", 32'(cpu_hold_o), 32'd1);

    // Control register read straight after reset
    ctrl_read("ctrl_rd0", 32'h00000001);
    chk("ack_one_cycle", 32'(wb_ack_o), 32'd0);
    chk("hold_after_rd", 32'(cpu_hold_o), 32'd1);

    // Releasing cpu_hold: falls the cycle after the ack
    start_req(32'h00F00000, 32'h0, 1'b1);
    wait_ack(lat);
    chk("wr0_lat", 32'(lat), 32'd1);
    chk("hold_at_ack", 32'(cpu_hold_o), 32'd1);
    end_req();
    chk("hold_fell", 32'(cpu_hold_o), 32'd0);

    // ROM 2 read with a stray ack from ROM 0 that must be ignored
    start_req(32'h00200010, 32'h0, 1'b0);
    @(posedge clock); #1;
    chk("rom2_strobe", 32'(rom_strobe_o), 32'h04);
    chk("rom2_cyc", 32'(rom_cyc_o), 32'h04);
    chk("rom2_ram_idle", 32'(ram_strobe_o), 32'h0);
    chk("rom2_dev_addr", dev_addr_o, 32'h00000010);
    chk("rom2_dev_we", 32'(dev_we_o), 32'd0);
    rom_ack_i = 5'b00001;
    @(posedge clock); #1;
    chk("rom2_stray_ack", 32'(wb_ack_o), 32'd0);
    rom_ack_i = '0;
    @(posedge clock); #1;
    rom_ack_i = 5'b00100;
    @(posedge clock); #1;
    chk("rom2_ack", 32'(wb_ack_o), 32'd1);
    chk("rom2_data", wb_data_o, 32'h12345678);
    chk("rom2_strobe_off", 32'(rom_strobe_o), 32'h0);
    rom_ack_i = '0;
    end_req();

    // RAM 1 never acks: timeout after 15 forwarding cycles
    ctrl_write(32'h1);
    start_req(32'h00900004, 32'h0, 1'b0);
    @(posedge clock); #1;
    chk("ram1_strobe", 32'(ram_strobe_o), 32'h2);
    chk("ram1_dev_addr", dev_addr_o, 32'h00000004);
    wait_ack(lat);
    chk("to_lat", 32'(lat), 32'd15);
    chk("to_data", wb_data_o, 32'hDEADBEEF);
    chk("to_strobe_off", 32'(ram_strobe_o), 32'h0);
    end_req();
    ctrl_read("ctrl_after_to", 32'h00000093);

    // Write-1-clear timeout together with loading cpu_hold=0
    ctrl_write(32'h2);
    chk("hold_cleared", 32'(cpu_hold_o), 32'd0);
    ctrl_read("ctrl_after_clr", 32'h00000090);

    // Unmapped read (select 5) and unmapped write (select A, past last RAM)
    start_req(32'h00500000, 32'h0, 1'b0);
    @(posedge clock); #1;
    chk("unmap_ack", 32'(wb_ack_o), 32'd1);
    chk("unmap_data", wb_data_o, 32'h0);
    chk("unmap_rom", 32'(rom_strobe_o), 32'h0);
    chk("unmap_ram", 32'(ram_strobe_o), 32'h0);
    end_req();
    start_req(32'h00A00000, 32'hFFFFFFFF, 1'b1);
    wait_ack(lat);
    chk("unmap_wr_lat", 32'(lat), 32'd1);
    chk("unmap_wr_ram", 32'(ram_strobe_o), 32'h0);
    end_req();
    ctrl_read("ctrl_after_unmap", 32'h00000090);

    // Host drops cyc in the second forwarding cycle
    start_req(32'h00000020, 32'h0, 1'b0);
    @(posedge clock); #1;
    chk("abort_strobe", 32'(rom_strobe_o), 32'h01);
    @(posedge clock); #1;
    wb_cyc_i = 1'b0;
    wb_strobe_i = 1'b0;
    @(posedge clock); #1;
    chk("abort_strobe_off", 32'(rom_strobe_o), 32'h0);
    chk("abort_no_ack", 32'(wb_ack_o), 32'd0);
    @(posedge clock); #1;
    chk("abort_no_ack2", 32'(wb_ack_o), 32'd0);
    ctrl_read("ctrl_pre_rst", 32'h00000090);

    // Asynchronous reset in the middle of a ROM 4 write
    start_req(32'h00400008, 32'h55AA55AA, 1'b1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rst_mid_strobe", 32'(rom_strobe_o), 32'h10);
    chk("rst_mid_we", 32'(dev_we_o), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_strobe", 32'(rom_strobe_o), 32'h0);
    chk("arst_dev_addr", dev_addr_o, 32'h0);
    chk("arst_dev_data", dev_data_o, 32'h0);
    chk("arst_dev_we", 32'(dev_we_o), 32'd0);
    chk("arst_ack", 32'(wb_ack_o), 32'd0);
    chk("arst_data", wb_data_o, 32'h0);
    chk("arst_hold", 32'(cpu_hold_o), 32'd1);
    wb_cyc_i = 1'b0;
    wb_strobe_i = 1'b0;
    wb_we_i = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_ack", 32'(wb_ack_o), 32'd0);
    chk("post_rst_strobe", 32'(rom_strobe_o), 32'h0);
    ctrl_read("ctrl_post_rst", 32'h00000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
